fifo_param_ctrl: RTL
====================

# fifo_param_ctrl

Parametrised synchronous FIFO with integrated storage, the next-generation replacement for the fixed 8-entry FIFO controller. It classifies each cycle's write/read request into an operation state, commits pointer, count and memory updates on the same edge, and reports per-request acknowledge/error one cycle later. It adds simultaneous read+write, synchronous clear, and programmable almost-full/almost-empty flags. It sits between a producer and a consumer in the same clock domain.

## Interface
- DATA_WIDTH, 32, width of din/dout
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH
- AF_LEVEL, DEPTH-1, almost_full asserted when data_count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when data_count <= AE_LEVEL

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear; priority over wr_en/rd_en
- wr_en  in  1  write request
- rd_en  in  1  read request
- din  in  DATA_WIDTH  write data, sampled with wr_en
- dout  out  DATA_WIDTH  registered read data
- data_count  out  ADDR_WIDTH+1  occupancy 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  status flags
- wr_ack, wr_err, rd_ack, rd_err  out  1 each  per-request result, decoded from state
- state  out  3  current operation state (debug)

## Operation
- States (3-bit): INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR, RD_WR, WR_RD_ERR.
- next_state from (clr, wr_en, rd_en, data_count), evaluated every cycle:
  - clr=1 -> INIT
  - no request -> NO_OP
  - wr only: full -> WR_ERROR, else WRITE
  - rd only: empty -> RD_ERROR, else READ
  - wr+rd: empty -> WR_RD_ERR (write done, read rejected); otherwise RD_WR (both done, including when full)
- Actions commit on the edge that loads next_state:
  - WRITE: mem[tail] <= din, tail+1, count+1
  - READ: dout <= mem[head], head+1, count-1
  - RD_WR: both; count unchanged
  - WR_RD_ERR: write only
  - error/NO_OP: no change; dout holds its value
  - INIT: head, tail, count, dout <= 0; memory contents not cleared
- RD_WR with head==tail (full): read returns old contents (read-before-write); new word is stored.
- Pointers wrap modulo DEPTH by natural ADDR_WIDTH overflow; count is ADDR_WIDTH+1 bits and never exceeds DEPTH or goes below 0.
- Decodes:
  - wr_ack = WRITE|RD_WR|WR_RD_ERR
  - wr_err = WR_ERROR
  - rd_ack = READ|RD_WR
  - rd_err = RD_ERROR|WR_RD_ERR
- Flags: full = (count==DEPTH), empty = (count==0); almost_* per parameter thresholds. All flags derive from registered count only.

## Timing
- Reset (reset_n low, asynchronous): state=INIT, head=tail=0, count=0, dout=0, empty=1, almost_empty=1, full=almost_full=0, all ack/err=0.
- Request sampled at edge N; ack/err and dout valid during cycle N..N+1; flags and count reflect the op after edge N. Latency is 1 cycle.
- Back-to-back requests accepted every cycle with no bubbles; the full/empty decision at edge N uses count already updated by edge N-1.
- clr and reset_n mid-stream: in-flight request is discarded, with no ack and no error.

## Structure
- Shared package fifo_param_pkg: 3-bit state encodings and the ack/err decode constants, reused by the bench.
- Sub-module fifo_next_ptr: combinational; from state, head, tail and count it produces we, re, next_head, next_tail and next_data_count. This is the parametrised successor of the address calculator.
- Top level holds the state register, pointer/count registers, DEPTH x DATA_WIDTH memory array and dout register.

## Test plan
- Reset: assert reset_n=0 mid-write -> next cycle count=0, empty=1, almost_empty=1, dout=0, state=INIT, all ack/err=0.
- Fill (ADDR_WIDTH=3): write 0x10..0x17 -> almost_full rises after 7th, full after 8th; 9th write -> wr_err=1 one cycle later, count stays 8.
- Drain: 8 reads -> dout=0x10..0x17 each with rd_ack; 9th read -> rd_err=1, dout holds 0x17, empty=1.
- Full + simultaneous: fill, then wr+rd with din=0xAA -> rd_ack=wr_ack=1, dout=oldest word, count=8; drain shows 0xAA last.
- Empty + simultaneous: wr+rd with din=0x55 -> state WR_RD_ERR, wr_ack=1, rd_err=1, count=1; next read returns 0x55.
- Wrap/clear: 20 alternating write/read pairs (pointers wrap twice), data in order. Then clr with count=3 -> INIT, count=0, empty=1; the next write/read round-trip is correct.

Source files
------------

// File: rtl/fifo_param_pkg.sv
// Shared state encodings and ack/err decode masks for the parametrised FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_param_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_NO_OP     = 3'd1,
    ST_WRITE     = 3'd2,
    ST_WR_ERROR  = 3'd3,
    ST_READ      = 3'd4,
    ST_RD_ERROR  = 3'd5,
    ST_RD_WR     = 3'd6,
    ST_WR_RD_ERR = 3'd7
  } state_e;

  // One bit per state encoding; bit n set means state n asserts that output.
  localparam logic [7:0] WR_ACK_MASK = 8'b1100_0100; // WRITE, RD_WR, WR_RD_ERR
  localparam logic [7:0] WR_ERR_MASK = 8'b0000_1000; // WR_ERROR
  localparam logic [7:0] RD_ACK_MASK = 8'b0101_0000; // READ, RD_WR
  localparam logic [7:0] RD_ERR_MASK = 8'b1010_0000; // RD_ERROR, WR_RD_ERR

  function automatic logic state_has(input logic [7:0] mask, input logic [2:0] st);
    return mask[st];
  endfunction

endpackage

// File: rtl/fifo_next_ptr.sv
// Combinational successor of the address calculator: write/read strobes, next pointers and count.
// Latency: zero (purely combinational, consumed on the same edge that loads the state).
// Backpressure: none; the state decode has already rejected illegal requests.
module fifo_next_ptr
  import fifo_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic [2:0]          state,
  input  logic [ADDR_WIDTH-1:0] head,
  input  logic [ADDR_WIDTH-1:0] tail,
  input  logic [ADDR_WIDTH:0]   data_count,
  output logic                we,
  output logic                re,
  output logic [ADDR_WIDTH-1:0] next_head,
  output logic [ADDR_WIDTH-1:0] next_tail,
  output logic [ADDR_WIDTH:0]   next_data_count
);

  localparam int CW = ADDR_WIDTH + 1;

  // Pointers wrap by natural overflow; simultaneous read+write leaves the count alone.
  always_comb begin
    we              = 1'b0;
    re              = 1'b0;
    next_head       = head;
    next_tail       = tail;
    next_data_count = data_count;
    case (state_e'(state))
      ST_INIT: begin
        next_head       = '0;
        next_tail       = '0;
        next_data_count = '0;
      end
      ST_WRITE, ST_WR_RD_ERR: begin
        we              = 1'b1;
        next_tail       = tail + ADDR_WIDTH'(1);
        next_data_count = data_count + CW'(1);
      end
      ST_READ: begin
        re              = 1'b1;
        next_head       = head + ADDR_WIDTH'(1);
        next_data_count = data_count - CW'(1);
      end
      ST_RD_WR: begin
        we        = 1'b1;
        re        = 1'b1;
        next_head = head + ADDR_WIDTH'(1);
        next_tail = tail + ADDR_WIDTH'(1);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fifo_param_ctrl.sv
// Parametrised single-clock FIFO: classifies each request, commits storage/pointers, reports ack/err.
// Latency: 1 cycle from request edge to ack/err, dout and updated flags.
// Backpressure: none on input; overflow/underflow requests are dropped and flagged via wr_err/rd_err.
module fifo_param_ctrl
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = CW'(AE_LEVEL);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   head_q, head_d;
  logic [ADDR_WIDTH-1:0]   tail_q, tail_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    we, re;
  logic                    full_w, empty_w;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  // Classify this cycle's request using the count committed by the previous edge.
  always_comb begin
    state_d = ST_NO_OP;
    if (clr) begin
      state_d = ST_INIT;
    end else if (wr_en && rd_en) begin
      // When full, the read frees the slot the write fills, so both succeed.
      state_d = empty_w ? ST_WR_RD_ERR : ST_RD_WR;
    end else if (wr_en) begin
      state_d = full_w ? ST_WR_ERROR : ST_WRITE;
    end else if (rd_en) begin
      state_d = empty_w ? ST_RD_ERROR : ST_READ;
    end
  end

  fifo_next_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_ptr (
    .state           (state_d),
    .head            (head_q),
    .tail            (tail_q),
    .data_count      (count_q),
    .we              (we),
    .re              (re),
    .next_head       (head_d),
    .next_tail       (tail_d),
    .next_data_count (count_d)
  );

  // Read data is taken from the pre-edge array, giving read-before-write when head==tail.
  always_comb begin
    dout_d = dout_q;
    if (state_d == ST_INIT) begin
      dout_d = '0;
    end else if (re) begin
      dout_d = mem_q[head_q];
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; contents deliberately survive reset and clear.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[tail_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign data_count   = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign state        = state_q;
  assign wr_ack       = state_has(WR_ACK_MASK, state_q);
  assign wr_err       = state_has(WR_ERR_MASK, state_q);
  assign rd_ack       = state_has(RD_ACK_MASK, state_q);
  assign rd_err       = state_has(RD_ERR_MASK, state_q);

endmodule
